// File: rtl/dmux4way16_dist_pkg.sv
// dmux4way16_dist_pkg: shared constants and way-decode helper for the 4-way distributor
package dmux_pkg;
    localparam int WIDTH = 16;
    localparam int WAYS = 4;
    localparam logic [1:0] WAY_A = 2'b00;
    localparam logic [1:0] WAY_B = 2'b01;
    localparam logic [1:0] WAY_C = 2'b10;
    localparam logic [1:0] WAY_D = 2'b11;
    function automatic logic [WAYS-1:0] way_onehot(input logic [1:0] sel);
        return WAYS'(1) << sel;
    endfunction
endpackage

// File: rtl/dmux4way16_dist_if.sv
// dmux4way16_dist_if: producer-side stream plus four consumer ways
interface dmux4way16_dist_if
    import dmux_pkg::*;
#(
    parameter int W = WIDTH
);
    logic [W-1:0]    in_data;
    logic [1:0]      in_sel;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_a;
    logic [W-1:0]    out_b;
    logic [W-1:0]    out_c;
    logic [W-1:0]    out_d;
    logic [WAYS-1:0] out_valid;
    logic [WAYS-1:0] out_ready;
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_c, out_d, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_a, out_b, out_c, out_d, out_valid
    );
endinterface

// File: rtl/dmux4way16_dist_slot.sv
// dist_slot: one-entry holding register; load wins over drain so a way sustains 1 word/cycle
module dist_slot
    import dmux_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         drain,
    output logic [W-1:0] q,
    output logic         full
);
    // data holds its last value after a drain; full clears only when drained without reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else begin
            if (load) q <= d;
            full <= load || (full && !drain);
        end
    end
endmodule

// File: rtl/dmux4way16_dist.sv
// dmux4way16_dist: steers one input stream to four independently back-pressured ways
module dmux4way16_dist
    import dmux_pkg::*;
(
    input logic clk,
    input logic rst_n,
    dmux4way16_dist_if.slave bus
);
    logic [WAYS-1:0]  full;
    logic [WAYS-1:0]  load;
    logic [WIDTH-1:0] q [WAYS];
    logic             ready;

    // a way can take a word if its slot is empty or is being drained this cycle
    assign ready = !full[bus.in_sel] || bus.out_ready[bus.in_sel];
    assign load = (bus.in_valid && ready) ? way_onehot(bus.in_sel) : '0;

    for (genvar i = 0; i < WAYS; i++) begin : g_slot
        dist_slot #(.W(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .d     (bus.in_data),
            .drain (bus.out_ready[i]),
            .q     (q[i]),
            .full  (full[i])
        );
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = full;
    assign bus.out_a     = q[WAY_A];
    assign bus.out_b     = q[WAY_B];
    assign bus.out_c     = q[WAY_C];
    assign bus.out_d     = q[WAY_D];
endmodule

// File: tb/tb_dmux4way16_dist.sv
// tb_dmux4way16_dist: table-driven check of routing, backpressure, idle and async reset
module tb_dmux4way16_dist;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    dmux4way16_dist_if bus ();
    dmux4way16_dist dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [15:0] d;
        logic [3:0]  ordy;
        logic        rdy;
        logic [3:0]  ev;
        logic [15:0] ea, eb, ec, ed;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] ev,
                            input logic [15:0] ea, eb, ec, ed);
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, " out_a"}, 32'(bus.out_a), 32'(ea));
        chk({tag, " out_b"}, 32'(bus.out_b), 32'(eb));
        chk({tag, " out_c"}, 32'(bus.out_c), 32'(ec));
        chk({tag, " out_d"}, 32'(bus.out_d), 32'(ed));
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] ordy);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 16'd3567, 4'b1111, 1'b1, 4'b0001, 16'd3567, 16'd0,    16'd0,  16'd0};
        tbl[1]  = '{1'b0, 2'd0, 16'd0,    4'b1111, 1'b1, 4'b0000, 16'd3567, 16'd0,    16'd0,  16'd0};
        tbl[2]  = '{1'b1, 2'd0, 16'd3567, 4'b1111, 1'b1, 4'b0001, 16'd3567, 16'd0,    16'd0,  16'd0};
        tbl[3]  = '{1'b1, 2'd1, 16'd1095, 4'b1111, 1'b1, 4'b0010, 16'd3567, 16'd1095, 16'd0,  16'd0};
        tbl[4]  = '{1'b1, 2'd2, 16'd25,   4'b1111, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd25, 16'd0};
        tbl[5]  = '{1'b1, 2'd3, 16'd1420, 4'b1111, 1'b1, 4'b1000, 16'd3567, 16'd1095, 16'd25, 16'd1420};
        tbl[6]  = '{1'b0, 2'd0, 16'd0,    4'b1111, 1'b1, 4'b0000, 16'd3567, 16'd1095, 16'd25, 16'd1420};
        tbl[7]  = '{1'b1, 2'd2, 16'd25,   4'b1011, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd25, 16'd1420};
        tbl[8]  = '{1'b1, 2'd2, 16'd99,   4'b1011, 1'b0, 4'b0100, 16'd3567, 16'd1095, 16'd25, 16'd1420};
        tbl[9]  = '{1'b1, 2'd3, 16'd1420, 4'b1011, 1'b1, 4'b1100, 16'd3567, 16'd1095, 16'd25, 16'd1420};
        tbl[10] = '{1'b1, 2'd2, 16'd99,   4'b1111, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd99, 16'd1420};
        tbl[11] = '{1'b0, 2'd0, 16'd7,    4'b1011, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd99, 16'd1420};
        tbl[12] = '{1'b0, 2'd1, 16'd7,    4'b1011, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd99, 16'd1420};
        tbl[13] = '{1'b0, 2'd2, 16'd7,    4'b1011, 1'b0, 4'b0100, 16'd3567, 16'd1095, 16'd99, 16'd1420};
        tbl[14] = '{1'b0, 2'd3, 16'd7,    4'b1011, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd99, 16'd1420};
        tbl[15] = '{1'b1, 2'd2, 16'd55,   4'b1111, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd55, 16'd1420};
        tbl[16] = '{1'b1, 2'd2, 16'd66,   4'b1111, 1'b1, 4'b0100, 16'd3567, 16'd1095, 16'd66, 16'd1420};
        tbl[17] = '{1'b0, 2'd0, 16'd0,    4'b1111, 1'b1, 4'b0000, 16'd3567, 16'd1095, 16'd66, 16'd1420};

        drive(1'b0, 2'd0, 16'd0, 4'b0000);
        #2;
        chk_outs("reset", 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1 chk($sformatf("reset in_ready sel%0d", s), 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ordy);
            #1 chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            @(negedge clk);
            chk_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed);
        end

        drive(1'b1, 2'd2, 16'd25, 4'b0000);
        @(negedge clk);
        drive(1'b1, 2'd3, 16'd1420, 4'b0000);
        @(negedge clk);
        drive(1'b0, 2'd0, 16'd0, 4'b0000);
        chk_outs("hold", 4'b1100, 16'd3567, 16'd1095, 16'd25, 16'd1420);
        #2 rst_n = 1'b0;
        #1 chk_outs("midreset", 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 16'd5, 4'b0000);
        @(negedge clk);
        drive(1'b0, 2'd0, 16'd0, 4'b0000);
        chk_outs("postreset", 4'b0100, 16'd0, 16'd0, 16'd5, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
